// File: rtl/fmdll_pkg.sv
// Shared constants and state encoding for the FMDLL feedback divider slice.
package fmdll_pkg;

    localparam int DIV_W_DEF     = 6;
    localparam int RST_RATIO_DEF = 8;
    localparam int MIN_RATIO     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fb_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk_in edge.
module fb_rst_sync (
    input  logic clk_in,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic meta;
    logic sync;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= 1'b1;
            sync <= meta;
        end
    end

    assign rst_sync_n = sync;

endmodule

// File: rtl/fb_divider.sv
// Programmable feedback divider for the DCO clock with glitch-free ratio reloads at wrap.
// Optional macro FB_DIVIDER_DUTY50_EN adds a negedge stage giving 50% duty on odd ratios.
module fb_divider
    import fmdll_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RST_RATIO = RST_RATIO_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_req,
    input  logic [DIV_W-1:0] load_val,
    output logic             div_m,
    output logic             tc,
    output logic             load_ack,
    output logic             busy,
    output logic [DIV_W-1:0] ratio
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_R = DIV_W'(MIN_RATIO);
    localparam logic [DIV_W-1:0] RST_R = DIV_W'(RST_RATIO);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

    logic             rst_sync_n;
    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] ratio_next;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] load_clamped;
    logic             pend_valid;
    logic             wrap;
    logic             apply;
    logic             run_next;
    logic [DIV_W:0]   high_cnt;
    logic             div_pos;
    logic             div_pos_next;
    logic             tc_next;

    fb_rst_sync u_rst_sync (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    assign load_clamped = (load_val < MIN_R) ? MIN_R : load_val;
    assign busy         = pend_valid;

    // Outputs are registered from the next-cycle count so div_m/tc line up with cnt.
    always_comb begin
        state_next   = en ? RUN : IDLE;
        run_next     = (state_next == RUN);
        wrap         = (state == RUN) && (cnt == ratio - ONE);
        apply        = pend_valid && ((state == IDLE) || wrap);
        ratio_next   = apply ? pend_val : ratio;
        cnt_next     = '0;
        if ((state == RUN) && run_next && !wrap) begin
            cnt_next = cnt + ONE;
        end
`ifdef FB_DIVIDER_DUTY50_EN
        high_cnt     = {1'b0, ratio_next} >> 1;
`else
        high_cnt     = ({1'b0, ratio_next} + ONE_X) >> 1;
`endif
        div_pos_next = run_next && ({1'b0, cnt_next} < high_cnt);
        tc_next      = run_next && (cnt_next == ratio_next - ONE);
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ratio    <= RST_R;
            div_pos  <= 1'b0;
            tc       <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ratio    <= ratio_next;
            div_pos  <= div_pos_next;
            tc       <= tc_next;
            load_ack <= apply;
        end
    end

    // A request landing on the apply edge wins, so it waits for the following wrap.
    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pend_val   <= RST_R;
            pend_valid <= 1'b0;
        end else if (load_req) begin
            pend_val   <= load_clamped;
            pend_valid <= 1'b1;
        end else if (apply) begin
            pend_valid <= 1'b0;
        end
    end

`ifdef FB_DIVIDER_DUTY50_EN
    logic div_neg;

    // Half-cycle delayed copy stretches the shortened odd-ratio high phase to N/2.
    always_ff @(negedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            div_neg <= 1'b0;
        end else begin
            div_neg <= div_pos;
        end
    end

    assign div_m = div_pos | (ratio[0] & div_neg);
`else
    assign div_m = div_pos;
`endif

endmodule

// File: doc/fb_divider.md
FB_DIVIDER -- requirements
Module: fb_divider

Interface
REQ-001 SHALL have parameter DIV_W, default 6, width of divide ratio.
REQ-002 SHALL have parameter RST_RATIO, default 8, ratio loaded at reset (2..2^DIV_W-1).
REQ-003 SHALL have port clk_in  input  1  DCO output clock, the sole clock; reset rst_n, asynchronous, active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  divider run enable, level.
REQ-006 SHALL have port load_req  input  1  single-cycle request to change the ratio.
REQ-007 SHALL have port load_val  input  DIV_W  new ratio N, sampled with load_req.
REQ-008 SHALL have port div_m  output  1  divided clock DIV_M to the downstream clock divider.
REQ-009 SHALL have port tc  output  1  terminal-count pulse, one clk_in cycle per output period.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when a new ratio takes effect.
REQ-011 SHALL have port busy  output  1  high while a requested ratio is pending.
REQ-012 SHALL have port ratio  output  DIV_W  active ratio in use.

Function
REQ-013 SHALL use two states: IDLE (en=0) and RUN (en=1); IDLE->RUN on first edge with en=1, RUN->IDLE on first edge with en=0.
REQ-014 SHALL in RUN count cnt 0..N-1, wrapping to 0 after N-1; N = active ratio.
REQ-015 SHALL drive div_m high (registered) for cnt < ceil(N/2), low otherwise; period exactly N clk_in cycles.
REQ-016 SHALL assert tc (registered) in the cycle cnt==N-1; tc precedes each div_m rising edge by one cycle.
REQ-017 SHALL in IDLE hold cnt=0, div_m=0, tc=0; first div_m rising edge one clk_in cycle after en sampled high.
REQ-018 SHALL clamp load_val < 2 to 2 when captured; no other arithmetic saturation.
REQ-019 SHALL capture load_val into a pending register on load_req and set busy the next cycle.
REQ-020 SHALL in RUN apply the pending ratio only at wrap (edge where cnt==N-1), so no truncated or stretched period is emitted.
REQ-021 SHALL in IDLE apply the pending ratio on the next edge.
REQ-022 SHALL pulse load_ack one cycle after the apply edge and clear busy in the same cycle.
REQ-023 SHALL, if load_req arrives while busy, overwrite the pending value; exactly one load_ack for the last value.
REQ-024 SHALL, on load_req coinciding with the wrap edge, capture it as pending for the following wrap (no same-edge apply).
REQ-025 SHALL on en deassert mid-period drop div_m to 0 next cycle and reset cnt; pending load is kept.

Reset
REQ-026 SHALL on rst_n low asynchronously set: state IDLE, cnt=0, div_m=0, tc=0, load_ack=0, busy=0, ratio=RST_RATIO, pending cleared.
REQ-027 SHALL abandon any pending load on reset mid-operation; no load_ack issued.
REQ-028 SHALL release reset synchronously to clk_in via a 2-flop reset synchroniser (assert async, deassert sync).

Configuration
REQ-029 SHALL honour macro FB_DIVIDER_DUTY50_EN.
REQ-030 SHALL with FB_DIVIDER_DUTY50_EN defined, for odd N, OR div_m with a negedge-clk_in copy so high time is N/2 cycles (50% duty); even N unchanged.
REQ-031 SHALL without the macro use only posedge logic; odd N gives high time (N+1)/2 cycles.

Structure
REQ-032 SHALL place DIV_W default, RST_RATIO default, minimum ratio constant 2, and the IDLE/RUN state enum in shared package fmdll_pkg.
REQ-033 SHALL use one sub-module, fb_rst_sync, for the reset synchroniser; all other logic flat.

Verification
REQ-034 SHALL cover reset defaults: rst_n low, en=1 -> div_m=0, tc=0, ratio=8, busy=0; after release div_m period 8 cycles, high 4.
REQ-035 SHALL cover odd ratio: load_val=5 -> period 5; high 3 cycles without macro, 2.5 cycles with FB_DIVIDER_DUTY50_EN.
REQ-036 SHALL cover mid-period load: N=8, load_val=3 at cnt=2 -> busy until wrap, load_ack one cycle after wrap, next periods 3, no short period.
REQ-037 SHALL cover back-to-back loads: load_val=6 then 10 before wrap -> single load_ack, ratio=10.
REQ-038 SHALL cover clamp and IDLE load: en=0, load_val=1 -> ratio=2 two edges later; en=1 -> div_m toggles every cycle.
REQ-039 SHALL cover reset mid-operation: busy=1, rst_n pulsed low -> busy=0, ratio=8, no load_ack.
